// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clk_meas waveform characterizer:
// FSM state encoding, default counter width and duty-cycle output width.
package clk_meas_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int DUTY_W    = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_REF,
        S_WAIT_RISE,
        S_HIGH,
        S_LOW,
        S_CALC,
        S_DONE,
        S_ERR
    } meas_state_t;

endpackage

// File: rtl/clk_meas_if.sv
// Control and result bus of clk_meas. The master side requests a
// measurement with start and collects the results; the slave side is the
// measuring block.
interface clk_meas_if import clk_meas_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
);
    logic              start;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  phase_cnt;
    logic [CNT_W-1:0]  ton_cnt;
    logic [CNT_W-1:0]  toff_cnt;
    logic [CNT_W:0]    period_cnt;
    logic [DUTY_W-1:0] duty_pct;

    modport master (
        output start,
        input  busy, done, err, phase_cnt, ton_cnt, toff_cnt, period_cnt, duty_pct
    );

    modport slave (
        input  start,
        output busy, done, err, phase_cnt, ton_cnt, toff_cnt, period_cnt, duty_pct
    );
endinterface

// File: rtl/clk_meas_div.sv
// Restoring divider for the duty-cycle percentage. One quotient bit per
// cycle, CNT_W+1 cycles per division. The dividend (ton*100) is always
// below divisor*2^(CNT_W+1) and the quotient never exceeds 100, so only
// DUTY_W quotient bits are kept; higher bits are always zero.
module clk_meas_div import clk_meas_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CNT_W+6:0]  dividend_i,
    input  logic [CNT_W:0]    divisor_i,
    output logic              done_o,
    output logic [DUTY_W-1:0] quot_o
);
    localparam int N    = CNT_W + 1;
    localparam int W    = 2 * CNT_W + 8;
    localparam int IT_W = $clog2(N + 1);

    logic [W-1:0]      rem_q;
    logic [W-1:0]      dsr_q;
    logic [DUTY_W-1:0] quot_q;
    logic [IT_W-1:0]   it_q;
    logic              run_q;
    logic              done_q;
    logic              ge;

    // Trial subtraction: does the shifted divisor fit into the remainder?
    always_comb begin
        ge = (rem_q >= dsr_q);
    end

    // Load on start, then one restoring step per cycle until N bits are out.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            dsr_q  <= '0;
            quot_q <= '0;
            it_q   <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                rem_q  <= W'(dividend_i);
                dsr_q  <= W'(divisor_i) << (N - 1);
                quot_q <= '0;
                it_q   <= '0;
                run_q  <= 1'b1;
            end else if (run_q) begin
                if (ge) begin
                    rem_q <= rem_q - dsr_q;
                end
                dsr_q  <= dsr_q >> 1;
                quot_q <= {quot_q[DUTY_W-2:0], ge};
                it_q   <= it_q + IT_W'(1);
                if (it_q == IT_W'(N - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign quot_o = quot_q;
endmodule

// File: rtl/clk_meas.sv
// clk_meas: samples an asynchronous waveform and measures, in clk cycles,
// its phase to a reference rising edge, its high time, low time and period.
// Optional feature macro: CLK_MEAS_DUTY_EN builds the duty-cycle divider;
// without it duty_pct reads 0 and CALC takes a single cycle.
module clk_meas import clk_meas_pkg::*; #(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig_in,
    input  logic       ref_in,
    clk_meas_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Synchronizer chains; both inputs see identical latency so it cancels
    // out of every measured interval.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        logic sig_q;
        logic ref_q;
        logic sig_src;
        logic ref_src;
        if (gi == 0) begin : g_src_first
            assign sig_src = sig_in;
            assign ref_src = ref_in;
        end else begin : g_src_chain
            assign sig_src = g_sync[gi-1].sig_q;
            assign ref_src = g_sync[gi-1].ref_q;
        end
        // One synchronizer stage per input.
        always_ff @(posedge clk) begin
            if (rst) begin
                sig_q <= 1'b0;
                ref_q <= 1'b0;
            end else begin
                sig_q <= sig_src;
                ref_q <= ref_src;
            end
        end
    end

    logic sig_s, ref_s, sig_prev_q, ref_prev_q;
    logic sig_rise, sig_fall, ref_rise;

    assign sig_s = g_sync[SYNC_STAGES-1].sig_q;
    assign ref_s = g_sync[SYNC_STAGES-1].ref_q;

    // Edge-detect flops behind the synchronizers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_prev_q <= 1'b0;
            ref_prev_q <= 1'b0;
        end else begin
            sig_prev_q <= sig_s;
            ref_prev_q <= ref_s;
        end
    end

    assign sig_rise = sig_s & ~sig_prev_q;
    assign sig_fall = ~sig_s & sig_prev_q;
    assign ref_rise = ref_s & ~ref_prev_q;

    meas_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] ton_q, ton_d;
    logic [CNT_W-1:0] toff_q, toff_d;
    logic [CNT_W:0]   period_q, period_d;
    logic             err_q, err_d;

`ifdef CLK_MEAS_DUTY_EN
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              div_start;
    logic              div_done;
    logic [DUTY_W-1:0] div_quot;
    logic [CNT_W+6:0]  div_dividend;
    logic [CNT_W:0]    div_divisor;

    // Operands are formed in the LOW cycle that sees the closing rise, so
    // the divisor equals the period being registered in that same cycle.
    assign div_dividend = {7'd0, ton_q} * (CNT_W+7)'(100);
    assign div_divisor  = {1'b0, ton_q} + {1'b0, cnt_q};

    clk_meas_div #(.CNT_W(CNT_W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (div_dividend),
        .divisor_i  (div_divisor),
        .done_o     (div_done),
        .quot_o     (div_quot)
    );
`endif

    // Next-state and result logic; every count is the cycle distance
    // between two detected events, with a timeout at the counter limit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        ton_d    = ton_q;
        toff_d   = toff_q;
        period_d = period_q;
        err_d    = err_q;
`ifdef CLK_MEAS_DUTY_EN
        duty_d    = duty_q;
        div_start = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_WAIT_REF;
                    cnt_d    = CNT_ONE;
                    err_d    = 1'b0;
                    phase_d  = '0;
                    ton_d    = '0;
                    toff_d   = '0;
                    period_d = '0;
`ifdef CLK_MEAS_DUTY_EN
                    duty_d   = '0;
`endif
                end
            end
            S_WAIT_REF: begin
                if (ref_rise && sig_rise) begin
                    phase_d = '0;
                    cnt_d   = CNT_ONE;
                    state_d = S_HIGH;
                end else if (ref_rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = S_WAIT_RISE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAIT_RISE: begin
                if (sig_rise) begin
                    phase_d = cnt_q;
                    cnt_d   = CNT_ONE;
                    state_d = S_HIGH;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (sig_fall) begin
                    ton_d   = cnt_q;
                    cnt_d   = CNT_ONE;
                    state_d = S_LOW;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_LOW: begin
                if (sig_rise) begin
                    toff_d   = cnt_q;
                    period_d = {1'b0, ton_q} + {1'b0, cnt_q};
                    state_d  = S_CALC;
`ifdef CLK_MEAS_DUTY_EN
                    div_start = 1'b1;
`endif
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_CALC: begin
`ifdef CLK_MEAS_DUTY_EN
                if (div_done) begin
                    duty_d  = div_quot;
                    state_d = S_DONE;
                end
`else
                state_d = S_DONE;
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                phase_d  = '0;
                ton_d    = '0;
                toff_d   = '0;
                period_d = '0;
                err_d    = 1'b1;
`ifdef CLK_MEAS_DUTY_EN
                duty_d   = '0;
`endif
                state_d  = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            phase_q  <= '0;
            ton_q    <= '0;
            toff_q   <= '0;
            period_q <= '0;
            err_q    <= 1'b0;
`ifdef CLK_MEAS_DUTY_EN
            duty_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            ton_q    <= ton_d;
            toff_q   <= toff_d;
            period_q <= period_d;
            err_q    <= err_d;
`ifdef CLK_MEAS_DUTY_EN
            duty_q   <= duty_d;
`endif
        end
    end

    assign bus.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.err        = err_q;
    assign bus.phase_cnt  = phase_q;
    assign bus.ton_cnt    = ton_q;
    assign bus.toff_cnt   = toff_q;
    assign bus.period_cnt = period_q;
`ifdef CLK_MEAS_DUTY_EN
    assign bus.duty_pct   = duty_q;
`else
    assign bus.duty_pct   = '0;
`endif
endmodule

// File: tb/tb_clk_meas.sv
// Directed bench for clk_meas (CNT_W = 8): clk-aligned waveforms with
// hand-computed phase/high/low/period/duty values, timeout, mid-run reset
// and a start request while busy.
module tb_clk_meas;
    localparam int CW = 8;
`ifdef CLK_MEAS_DUTY_EN
    localparam bit DUTY_ON = 1'b1;
    localparam int LAT     = 14;   // negedges from closing sig drive to done
`else
    localparam bit DUTY_ON = 1'b0;
    localparam int LAT     = 5;
`endif

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic sig_in = 1'b0;
    logic ref_in = 1'b0;

    int n_chk       = 0;
    int n_err       = 0;
    int done_pulses = 0;

    always #5 clk = ~clk;

    clk_meas_if #(.CNT_W(CW)) bus();

    clk_meas #(.CNT_W(CW), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .ref_in (ref_in),
        .bus    (bus)
    );

    always @(negedge clk) begin
        if (bus.done) done_pulses++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit, output int k);
        k = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (bus.done) begin
                k = i;
                break;
            end
        end
        chk("done_seen", int'(k > 0), 1);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_meas(input string name, input int ph, input int hi,
                            input int lo, input int duty, input bit dbl);
        int k;
        int p0;
        sig_in = 1'b0;
        ref_in = 1'b0;
        repeat (5) tick();
        pulse_start();
        @(negedge clk);
        chk({name, "_busy_on"}, int'(bus.busy), 1);
        chk({name, "_err_clr"}, int'(bus.err), 0);
        repeat (2) tick();
        ref_in = 1'b1;
        repeat (ph) tick();
        sig_in = 1'b1;
        p0 = done_pulses;
        if (dbl) begin
            pulse_start();
            repeat (hi - 1) tick();
        end else begin
            repeat (hi) tick();
        end
        sig_in = 1'b0;
        repeat (lo) tick();
        sig_in = 1'b1;
        wait_done(60, k);
        chk({name, "_latency"}, k, LAT);
        chk({name, "_busy_off"}, int'(bus.busy), 0);
        chk({name, "_err"}, int'(bus.err), 0);
        chk({name, "_phase"}, int'(bus.phase_cnt), ph);
        chk({name, "_ton"}, int'(bus.ton_cnt), hi);
        chk({name, "_toff"}, int'(bus.toff_cnt), lo);
        chk({name, "_period"}, int'(bus.period_cnt), hi + lo);
        chk({name, "_duty"}, int'(bus.duty_pct), DUTY_ON ? duty : 0);
        $display("meas %s: phase=%0d ton=%0d toff=%0d period=%0d duty=%0d err=%0d",
                 name, bus.phase_cnt, bus.ton_cnt, bus.toff_cnt, bus.period_cnt,
                 bus.duty_pct, bus.err);
        repeat (5) tick();
        chk({name, "_one_done"}, done_pulses - p0, 1);
        chk({name, "_hold_ton"}, int'(bus.ton_cnt), hi);
    endtask

    initial begin
        int k;
        bus.start = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_phase", int'(bus.phase_cnt), 0);
        chk("rst_ton", int'(bus.ton_cnt), 0);
        chk("rst_toff", int'(bus.toff_cnt), 0);
        chk("rst_period", int'(bus.period_cnt), 0);
        chk("rst_duty", int'(bus.duty_pct), 0);
        tick();
        rst = 1'b0;
        tick();

        run_meas("basic", 4, 3, 7, 30, 1'b0);
        run_meas("same_edge", 0, 5, 5, 50, 1'b0);

        // Timeout: reference rises, sig never does.
        sig_in = 1'b0;
        ref_in = 1'b0;
        repeat (5) tick();
        pulse_start();
        repeat (2) tick();
        ref_in = 1'b1;
        wait_done(400, k);
        chk("to_window", int'(k >= 250 && k <= 270), 1);
        chk("to_err", int'(bus.err), 1);
        chk("to_busy", int'(bus.busy), 0);
        chk("to_phase", int'(bus.phase_cnt), 0);
        chk("to_period", int'(bus.period_cnt), 0);
        chk("to_duty", int'(bus.duty_pct), 0);
        $display("meas timeout: done after %0d cycles err=%0d", k, bus.err);
        repeat (3) tick();
        chk("to_err_held", int'(bus.err), 1);

        // Reset while in HIGH.
        sig_in = 1'b0;
        ref_in = 1'b0;
        repeat (5) tick();
        pulse_start();
        repeat (2) tick();
        ref_in = 1'b1;
        repeat (2) tick();
        sig_in = 1'b1;
        repeat (6) tick();
        chk("pre_rst_busy", int'(bus.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_done", int'(bus.done), 0);
        chk("mid_rst_err", int'(bus.err), 0);
        chk("mid_rst_phase", int'(bus.phase_cnt), 0);
        repeat (3) tick();
        chk("mid_rst_idle", int'(bus.busy), 0);
        $display("meas mid_reset: busy=%0d phase=%0d", bus.busy, bus.phase_cnt);

        run_meas("after_rst", 3, 4, 6, 40, 1'b0);
        run_meas("dbl_start", 2, 3, 7, 30, 1'b1);
        run_meas("glitch", 2, 1, 9, 10, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
